// File: rtl/spatial_conv_pkg.sv
// Shared types and sizing helpers for the spatial convolution window feeders.
package spatial_conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PRESENT,
    ST_HELD,
    ST_ADVANCE,
    ST_DONE
  } feeder_state_t;

  // Pixels that must be buffered before the first K x K window is complete.
  function automatic int line_buffer_depth(input int k, input int n_cols);
    return (k - 1) * n_cols + k;
  endfunction

  // Number of fully in-frame K x K windows in an n_rows x n_cols map.
  function automatic int window_count(input int n_rows, input int n_cols, input int k);
    return (n_rows - k + 1) * (n_cols - k + 1);
  endfunction

endpackage

// File: rtl/spatial_window_feeder_if.sv
// Memory read port and window handshake between a feeder and its neighbours.
interface spatial_window_feeder_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 3
);
  logic                  mem_rd_en_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_data_i;
  logic [DATA_WIDTH-1:0] window_o [0:KERNEL_SIZE*KERNEL_SIZE-1];
  logic                  window_valid_o;
  logic                  hold_window_i;

  modport master (
    output mem_rd_en_o, mem_addr_o, window_o, window_valid_o,
    input  mem_data_i, hold_window_i
  );

  modport slave (
    input  mem_rd_en_o, mem_addr_o, window_o, window_valid_o,
    output mem_data_i, hold_window_i
  );
endinterface

// File: rtl/window_buffer.sv
// Line buffer: a shift register holding the last (K-1)*LINE_LENGTH+K pixels.
// taps_o is newest-first: taps_o[r*K+c] is the pixel r lines and c pixels
// older than the most recently shifted-in one.
module window_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int LINE_LENGTH = 28,
  parameter int WINDOW_SIZE = 3
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] taps_o [0:WINDOW_SIZE*WINDOW_SIZE-1]
);
  localparam int DEPTH = (WINDOW_SIZE - 1) * LINE_LENGTH + WINDOW_SIZE;

  logic [DATA_WIDTH-1:0] line_q [0:DEPTH-1];

  // Shift one pixel in per enable; oldest pixel falls off the end.
  // NOTE: this storage array is reset because the window must read all-zero after reset.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
    end else if (enable_i) begin
      line_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
    end
  end

  for (genvar r = 0; r < WINDOW_SIZE; r++) begin : g_row
    for (genvar c = 0; c < WINDOW_SIZE; c++) begin : g_col
      assign taps_o[r*WINDOW_SIZE+c] = line_q[r*LINE_LENGTH+c];
    end
  end
endmodule

// File: rtl/spatial_window_feeder.sv
// Streams one channel of a feature map from memory through a line buffer and
// presents each in-frame K x K window under a hold/release handshake.
// Optional: SPATIAL_WINDOW_FEEDER_PREFETCH_EN fetches the next pixel into a
// staging register while a window is held, shortening the release gap.
module spatial_window_feeder
  import spatial_conv_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int N_ROWS      = 28,
  parameter int N_COLS      = 28,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  base_addr_i,
  output logic                   busy_o,
  output logic                   done_o,
  spatial_window_feeder_if.master win_if
);
  localparam int DEPTH  = line_buffer_depth(KERNEL_SIZE, N_COLS);
  localparam int N_WIN  = window_count(N_ROWS, N_COLS, KERNEL_SIZE);
  localparam int N_TAPS = KERNEL_SIZE * KERNEL_SIZE;
  localparam int IDX_W  = $clog2(N_ROWS * N_COLS + 1);
  localparam int COL_W  = $clog2(N_COLS);
  localparam int WIN_W  = $clog2(N_WIN + 1);

  localparam logic [IDX_W-1:0] FILL_LEN  = IDX_W'(DEPTH);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(N_COLS - 1);
  localparam logic [COL_W-1:0] COL_READY = COL_W'(KERNEL_SIZE - 1);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(N_WIN - 1);

  feeder_state_t         state_q;
  logic                  rd_en_q, rd_q, valid_q;
  logic [ADDR_WIDTH-1:0] addr_q, base_q, base_sel;
  logic [IDX_W-1:0]      issue_idx_q;   // raster index of the next pixel to read
  logic [COL_W-1:0]      issue_col_q;   // column of the next pixel to read
  logic [COL_W-1:0]      last_col_q;    // column of the most recently read pixel
  logic [WIN_W-1:0]      win_cnt_q;
  logic                  issue_c, release_c, last_release_c, shift_en;
  logic [DATA_WIDTH-1:0] shift_data;
  logic [DATA_WIDTH-1:0] taps [0:N_TAPS-1];

  assign base_sel = (state_q == ST_IDLE) ? base_addr_i : base_q;

  // Decide whether a read is issued at the coming edge.
  // NOTE: every signal gets a default first so no latch is inferred.
  always_comb begin
    release_c      = (state_q == ST_HELD) && !win_if.hold_window_i;
    last_release_c = release_c && (win_cnt_q == WIN_LAST);
    issue_c        = 1'b0;
    case (state_q)
      ST_IDLE:    issue_c = start_i;
      ST_FILL:    issue_c = issue_idx_q < FILL_LEN;
`ifdef SPATIAL_WINDOW_FEEDER_PREFETCH_EN
      ST_PRESENT: issue_c = win_if.hold_window_i && (issue_idx_q < IDX_W'(N_ROWS * N_COLS));
      ST_HELD:    issue_c = release_c && !last_release_c && (last_col_q < COL_READY);
`else
      ST_HELD:    issue_c = release_c && !last_release_c;
`endif
      ST_ADVANCE: issue_c = rd_en_q && (last_col_q < COL_READY);
      default:    issue_c = 1'b0;
    endcase
  end

`ifdef SPATIAL_WINDOW_FEEDER_PREFETCH_EN
  logic                  pf_rd_q, pf_q, staged_valid_q, stage_c, unstage_c;
  logic [DATA_WIDTH-1:0] staged_q;

  // A prefetched pixel is parked while the window is still held, and shifted
  // on release; if the release comes first it shifts straight from memory.
  always_comb begin
    stage_c    = rd_q && pf_q && (state_q == ST_HELD) && win_if.hold_window_i;
    unstage_c  = release_c && staged_valid_q;
    shift_en   = (rd_q && !stage_c) || unstage_c;
    shift_data = unstage_c ? staged_q : win_if.mem_data_i;
  end

  // Prefetch tagging and staging register.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pf_rd_q        <= 1'b0;
      pf_q           <= 1'b0;
      staged_valid_q <= 1'b0;
      staged_q       <= '0;
    end else begin
      pf_rd_q <= issue_c && (state_q == ST_PRESENT);
      pf_q    <= pf_rd_q;
      if (stage_c) begin
        staged_q       <= win_if.mem_data_i;
        staged_valid_q <= 1'b1;
      end else if (unstage_c) begin
        staged_valid_q <= 1'b0;
      end
    end
  end
`else
  // Every returning read goes straight into the line buffer.
  always_comb begin
    shift_en   = rd_q;
    shift_data = win_if.mem_data_i;
  end
`endif

  // Control FSM, read address generation and window bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_IDLE;
      rd_en_q     <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      base_q      <= '0;
      issue_idx_q <= '0;
      issue_col_q <= '0;
      last_col_q  <= '0;
      win_cnt_q   <= '0;
      valid_q     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      rd_en_q <= issue_c;
      rd_q    <= rd_en_q;
      if (issue_c) begin
        addr_q      <= base_sel + ADDR_WIDTH'(issue_idx_q);
        issue_idx_q <= issue_idx_q + 1'b1;
        last_col_q  <= issue_col_q;
        issue_col_q <= (issue_col_q == COL_LAST) ? '0 : issue_col_q + 1'b1;
      end
      case (state_q)
        ST_IDLE: if (start_i) begin
          state_q <= ST_FILL;
          base_q  <= base_addr_i;
          busy_o  <= 1'b1;
        end
        ST_FILL: if (!rd_en_q) begin
          state_q <= ST_PRESENT;
          valid_q <= 1'b1;
        end
        ST_PRESENT: if (win_if.hold_window_i) state_q <= ST_HELD;
        ST_HELD: if (release_c) begin
          valid_q   <= 1'b0;
          win_cnt_q <= win_cnt_q + 1'b1;
          if (last_release_c) begin
            state_q <= ST_DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end else begin
            state_q <= ST_ADVANCE;
          end
        end
        ST_ADVANCE: if (!rd_en_q) begin
          state_q <= ST_PRESENT;
          valid_q <= 1'b1;
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          done_o      <= 1'b0;
          issue_idx_q <= '0;
          issue_col_q <= '0;
          last_col_q  <= '0;
          win_cnt_q   <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  window_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINE_LENGTH(N_COLS),
    .WINDOW_SIZE(KERNEL_SIZE)
  ) u_window_buffer (
    .clock_i (clock_i),
    .reset_ni(reset_ni),
    .enable_i(shift_en),
    .data_i  (shift_data),
    .taps_o  (taps)
  );

  assign win_if.mem_rd_en_o    = rd_en_q;
  assign win_if.mem_addr_o     = addr_q;
  assign win_if.window_valid_o = valid_q;

  // Buffer taps are newest-first; the window is oldest-first in raster order.
  for (genvar r = 0; r < KERNEL_SIZE; r++) begin : g_row
    for (genvar c = 0; c < KERNEL_SIZE; c++) begin : g_col
      assign win_if.window_o[r*KERNEL_SIZE+c] =
        taps[(KERNEL_SIZE-1-r)*KERNEL_SIZE + (KERNEL_SIZE-1-c)];
    end
  end
endmodule
